// File: rtl/contador_hex_pkg.sv
// -----------------------------------------------------------------------------
// contador_pkg
// Shared types and digit arithmetic for the four-digit display counter.
//
// Contents:
//   digito_t           - one display digit (nibble)
//   estado_t           - run/stop FSM state {PARADO, CONTANDO}
//   NUM_DIGITOS        - number of display digits
//   DIGITO_MAX         - largest legal digit value (9 in BCD, 15 in hex)
//   limita_carga()     - conditions a preset nibble before it is stored
//   incrementa_digito  - one digit of the up carry chain
//   decrementa_digito  - one digit of the down borrow chain
//
// Build option: CONTADOR_BCD_EN selects decimal digits (0-9); when it is left
// undefined every digit is a plain hexadecimal nibble (0-F).
// -----------------------------------------------------------------------------
package contador_pkg;

  typedef logic [3:0] digito_t;

  typedef enum logic [0:0] {
    PARADO   = 1'b0,
    CONTANDO = 1'b1
  } estado_t;

  localparam int NUM_DIGITOS = 4;

`ifdef CONTADOR_BCD_EN
  localparam digito_t DIGITO_MAX = 4'd9;
`else
  localparam digito_t DIGITO_MAX = 4'd15;
`endif

  // Decimal digits cannot hold A-F, so such preset nibbles saturate at 9.
  // In hexadecimal builds every nibble is already legal and passes through.
  function automatic digito_t limita_carga(input digito_t d);
    digito_t r;
`ifdef CONTADOR_BCD_EN
    if (d > DIGITO_MAX) begin
      r = DIGITO_MAX;
    end else begin
      r = d;
    end
`else
    r = d;
`endif
    return r;
  endfunction

  // Returns {carry_out, new_digit}; the digit only moves when a carry arrives.
  function automatic logic [4:0] incrementa_digito(input digito_t d, input logic cin);
    logic [4:0] r;
    if (!cin) begin
      r = {1'b0, d};
    end else if (d == DIGITO_MAX) begin
      r = {1'b1, 4'd0};
    end else begin
      r = {1'b0, d + 4'd1};
    end
    return r;
  endfunction

  // Returns {borrow_out, new_digit}; the digit only moves when a borrow arrives.
  function automatic logic [4:0] decrementa_digito(input digito_t d, input logic bin);
    logic [4:0] r;
    if (!bin) begin
      r = {1'b0, d};
    end else if (d == 4'd0) begin
      r = {1'b1, DIGITO_MAX};
    end else begin
      r = {1'b0, d - 4'd1};
    end
    return r;
  endfunction

endpackage

// File: rtl/contador_hex_sincroniza_borda.sv
// -----------------------------------------------------------------------------
// sincroniza_borda
// Brings an asynchronous level into the clk domain through two flops and
// produces a single-cycle pulse for every rising level seen after them.
//
// Ports:
//   clk      in   1  clock, rising edge
//   reset    in   1  synchronous, active-high; clears all three flops
//   entrada  in   1  raw asynchronous level
//   pulso    out  1  high for one cycle per rising level (s2 & ~s3)
//
// Latency: entrada first sampled high at edge k -> pulso high during the
// cycle that follows edge k+1.
// -----------------------------------------------------------------------------
module sincroniza_borda
  import contador_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic entrada,
  output logic pulso
);

  logic s1_r;
  logic s2_r;
  logic s3_r;

  // Two-stage synchronizer followed by the edge-history register.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
      s3_r <= 1'b0;
    end else begin
      s1_r <= entrada;
      s2_r <= s1_r;
      s3_r <= s2_r;
    end
  end

  assign pulso = s2_r & ~s3_r;

endmodule

// File: rtl/contador_hex.sv
// -----------------------------------------------------------------------------
// contador_hex
// Four-digit up/down counter feeding the seven-segment decoders. A start/stop
// button toggles between PARADO and CONTANDO, a prescaler paces the count at
// one step every DIV clocks, and a level-sensitive load presets all digits.
//
// Parameters:
//   DIV         clock cycles per count step, 1 .. 2**26 (default 50_000_000)
//
// Ports:
//   clk         in   1   board clock, rising edge
//   reset       in   1   synchronous, active-high
//   btn_start   in   1   raw asynchronous start/stop request
//   up_down     in   1   1 = count up, 0 = count down
//   load        in   1   synchronous preset, level-sensitive
//   load_value  in   16  preset value, nibble i -> digit i
//   digit3..0   out  4   count digits, most to least significant (registered)
//   running     out  1   high while in CONTANDO (registered)
//   wrap        out  1   one-cycle pulse aligned with a full-range wrap
//
// Build option: CONTADOR_BCD_EN makes each digit decimal (0-9, wrap at
// 9999 <-> 0000, preset nibbles above 9 saturate to 9). Undefined: hex digits.
// -----------------------------------------------------------------------------
module contador_hex
  import contador_pkg::*;
#(
  parameter int unsigned DIV = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start,
  input  logic        up_down,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [3:0]  digit3,
  output logic [3:0]  digit2,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic        running,
  output logic        wrap
);

  // $clog2(1) is 0, so the prescaler keeps at least one bit.
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

  logic                          start_pulso_s;
  estado_t                       estado_r;
  logic                          running_r;
  logic [PW-1:0]                 presc_r;
  logic                          tick_s;
  digito_t [NUM_DIGITOS-1:0]     digito_r;
  digito_t [NUM_DIGITOS-1:0]     prox_s;
  logic                          fim_cadeia_s;
  logic                          wrap_r;

  sincroniza_borda u_sincroniza_borda (
    .clk     (clk),
    .reset   (reset),
    .entrada (btn_start),
    .pulso   (start_pulso_s)
  );

  // Run/stop FSM; running is kept as its own register beside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      estado_r  <= PARADO;
      running_r <= 1'b0;
    end else if (start_pulso_s) begin
      case (estado_r)
        PARADO: begin
          estado_r  <= CONTANDO;
          running_r <= 1'b1;
        end
        CONTANDO: begin
          estado_r  <= PARADO;
          running_r <= 1'b0;
        end
        default: begin
          estado_r  <= PARADO;
          running_r <= 1'b0;
        end
      endcase
    end
  end

  // Count-step strobe. A start edge while counting means the counter is about
  // to stop, and the digits must already be frozen on that same edge.
  always_comb begin
    if (running_r && (presc_r == PRESC_MAX) && !load && !start_pulso_s) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // Prescaler: runs only while counting; any stop, load or step restarts the
  // phase so the next start always waits a full DIV.
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_r <= '0;
    end else if (load || tick_s || !running_r || start_pulso_s) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Next count value: ripple carry (up) or borrow (down) across the digits.
  // A carry/borrow leaving the top digit is a full-range wrap.
  always_comb begin
    logic cadeia_v;
    cadeia_v = 1'b1;
    prox_s   = digito_r;
    for (int i = 0; i < NUM_DIGITOS; i++) begin
      if (up_down) begin
        {cadeia_v, prox_s[i]} = incrementa_digito(digito_r[i], cadeia_v);
      end else begin
        {cadeia_v, prox_s[i]} = decrementa_digito(digito_r[i], cadeia_v);
      end
    end
    fim_cadeia_s = cadeia_v;
  end

  // Digit registers: load wins over a count step.
  always_ff @(posedge clk) begin
    if (reset) begin
      digito_r <= '0;
    end else if (load) begin
      for (int i = 0; i < NUM_DIGITOS; i++) begin
        digito_r[i] <= limita_carga(load_value[4*i +: 4]);
      end
    end else if (tick_s) begin
      digito_r <= prox_s;
    end
  end

  // Wrap flag: set by a wrapping step, cleared by any other cycle or a load.
  always_ff @(posedge clk) begin
    if (reset) begin
      wrap_r <= 1'b0;
    end else if (load) begin
      wrap_r <= 1'b0;
    end else begin
      wrap_r <= tick_s & fim_cadeia_s;
    end
  end

  assign digit3  = digito_r[3];
  assign digit2  = digito_r[2];
  assign digit1  = digito_r[1];
  assign digit0  = digito_r[0];
  assign running = running_r;
  assign wrap    = wrap_r;

endmodule
